gpio_irq: RTL and testbench

GPIO_IRQ -- requirements
Module: gpio_irq

---
 rtl/gpio_pkg.sv | 29 ++
 rtl/gpio_sync.sv | 47 ++++
 rtl/gpio_irq.sv | 195 +++++++++++++++++++
 tb/tb_gpio_irq.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// -----------------------------------------------------------------------------
// gpio_pkg
//
// Shared definitions for the GPIO block with edge-triggered interrupts.
//
// Contents:
//   REG_W        width of the register bus (write data and read data)
//   ADDR_W       width of the register index
//   ADDR_*       register index map used by gpio_irq and by software models
//   SYNC_MAX     deepest supported input synchroniser
// -----------------------------------------------------------------------------
package gpio_pkg;

    localparam int REG_W    = 32;
    localparam int ADDR_W   = 3;
    localparam int SYNC_MAX = 4;

    // Register index map. OUT_SET / OUT_CLR / OUT_TGL are write-side views of
    // OUT and read back as OUT. STATUS is write-1-to-clear.
    localparam logic [ADDR_W-1:0] ADDR_DIR     = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_OUT     = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_OUT_SET = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_OUT_CLR = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_OUT_TGL = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_RISE_EN = 3'd5;
    localparam logic [ADDR_W-1:0] ADDR_FALL_EN = 3'd6;
    localparam logic [ADDR_W-1:0] ADDR_STATUS  = 3'd7;

endpackage : gpio_pkg

// File: rtl/gpio_sync.sv
// -----------------------------------------------------------------------------
// gpio_sync
//
// Multi-flop synchroniser for asynchronous pad inputs. Each bit is sampled
// independently; no attempt is made to keep bits of a bus coherent, which is
// fine for GPIO since every pin is an independent signal.
//
// Parameters:
//   WIDTH        number of bits synchronised (1..32)
//   SYNC_STAGES  number of flip-flops in the chain (2..4)
//
// Ports:
//   clk     in   destination clock
//   rst_n   in   asynchronous active-low reset, clears every stage
//   d       in   raw asynchronous inputs
//   q       out  synchronised inputs, SYNC_STAGES cycles after d
// -----------------------------------------------------------------------------
module gpio_sync
    import gpio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [SYNC_STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q = stage_q[SYNC_STAGES-1];

endmodule : gpio_sync

// File: rtl/gpio_irq.sv
// -----------------------------------------------------------------------------
// gpio_irq
//
// General-purpose I/O block: per-pin direction and output value registers,
// synchronised pin inputs with per-pin rising/falling edge detection, a
// sticky write-1-to-clear STATUS register and a registered level interrupt.
// Pad tristate buffers live in the board top and are built from pin_o/pin_oe.
//
// Register interface: valid is a one-cycle write strobe with no back-pressure
// (there is no ready); every cycle with valid=1 performs exactly one write of
// data to register addr at the next rising edge. Reads need no strobe: data_o
// is registered every cycle from the register selected by addr.
//
// Parameters:
//   WIDTH        number of pins (1..32)
//   SYNC_STAGES  input synchroniser depth (2..4)
//
// Ports:
//   clk     in   single clock, all state updates on the rising edge
//   rst_n   in   asynchronous assert, active-low reset
//   valid   in   write strobe
//   addr    in   register index for both write and read
//   data    in   write data; bits at WIDTH and above are ignored
//   data_o  out  registered read data for addr; bits at WIDTH and above are 0
//   pin_i   in   raw pad inputs, asynchronous to clk
//   pin_o   out  pad output values (OUT register)
//   pin_oe  out  pad output enables, 1 = drive (DIR register)
//   irq     out  registered OR of STATUS
// -----------------------------------------------------------------------------
module gpio_irq
    import gpio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid,
    input  logic [ADDR_W-1:0] addr,
    input  logic [REG_W-1:0]  data,
    output logic [REG_W-1:0]  data_o,
    input  logic [WIDTH-1:0]  pin_i,
    output logic [WIDTH-1:0]  pin_o,
    output logic [WIDTH-1:0]  pin_oe,
    output logic              irq
);

    // Warm-up counter: after reset release the synchroniser and history
    // register are still flushing their reset zeros, so a pin held high
    // through reset would look like a rising edge. Edge detection stays
    // masked until the counter reaches zero.
    localparam int                WARM_INIT = SYNC_STAGES + 1;
    localparam int                WARM_W    = $clog2(WARM_INIT + 1);
    localparam logic [WARM_W-1:0] WARM_LOAD = WARM_W'(WARM_INIT);

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic [WIDTH-1:0]  dir_q;
    logic [WIDTH-1:0]  out_q;
    logic [WIDTH-1:0]  rise_en_q;
    logic [WIDTH-1:0]  fall_en_q;
    logic [WIDTH-1:0]  status_q;
    logic [WIDTH-1:0]  hist_q;
    logic [WARM_W-1:0] warm_q;
    logic [REG_W-1:0]  data_o_q;
    logic              irq_q;

    // ---------------------------------------------------------------------
    // Combinational next-state
    // ---------------------------------------------------------------------
    logic [WIDTH-1:0]  sampled;
    logic [WIDTH-1:0]  wdata;
    logic [WIDTH-1:0]  dir_d;
    logic [WIDTH-1:0]  out_d;
    logic [WIDTH-1:0]  rise_en_d;
    logic [WIDTH-1:0]  fall_en_d;
    logic [WIDTH-1:0]  status_d;
    logic [WIDTH-1:0]  rise;
    logic [WIDTH-1:0]  fall;
    logic [WIDTH-1:0]  set_mask;
    logic [WIDTH-1:0]  clr_mask;
    logic              warm_done;
    logic [REG_W-1:0]  rd_word;

    // Upper write-data bits are deliberately dropped for narrow instances.
    logic              unused_data;
    assign unused_data = ^data;

    assign wdata = data[WIDTH-1:0];

    gpio_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pin_i),
        .q     (sampled)
    );

    // Edge detection compares the synchronised value with its one-cycle
    // history.
    assign warm_done = (warm_q == '0);
    assign rise      = sampled & ~hist_q;
    assign fall      = ~sampled & hist_q;

    // Register writes.
    always_comb begin
        dir_d     = dir_q;
        out_d     = out_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        clr_mask  = '0;
        if (valid) begin
            case (addr)
                ADDR_DIR:     dir_d     = wdata;
                ADDR_OUT:     out_d     = wdata;
                ADDR_OUT_SET: out_d     = out_q | wdata;
                ADDR_OUT_CLR: out_d     = out_q & ~wdata;
                ADDR_OUT_TGL: out_d     = out_q ^ wdata;
                ADDR_RISE_EN: rise_en_d = wdata;
                ADDR_FALL_EN: fall_en_d = wdata;
                ADDR_STATUS:  clr_mask  = wdata;
                default:      ;
            endcase
        end
    end

    // STATUS: enables gate only new edges, so bits already set stay set when
    // an enable is later cleared. Set is applied after clear, so a
    // simultaneous W1C and qualifying edge leaves the bit at 1.
    always_comb begin
        set_mask = '0;
        if (warm_done) begin
            set_mask = (rise & rise_en_q) | (fall & fall_en_q);
        end
        status_d = (status_q & ~clr_mask) | set_mask;
    end

    // Read mux. The write-only views of OUT read back as OUT; the raw
    // synchronised pin values are intentionally not visible.
    always_comb begin
        rd_word = '0;
        case (addr)
            ADDR_DIR:     rd_word[WIDTH-1:0] = dir_q;
            ADDR_OUT,
            ADDR_OUT_SET,
            ADDR_OUT_CLR,
            ADDR_OUT_TGL: rd_word[WIDTH-1:0] = out_q;
            ADDR_RISE_EN: rd_word[WIDTH-1:0] = rise_en_q;
            ADDR_FALL_EN: rd_word[WIDTH-1:0] = fall_en_q;
            ADDR_STATUS:  rd_word[WIDTH-1:0] = status_q;
            default:      ;
        endcase
    end

    // ---------------------------------------------------------------------
    // Sequential
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_q     <= '0;
            out_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            status_q  <= '0;
            hist_q    <= '0;
            warm_q    <= WARM_LOAD;
            data_o_q  <= '0;
            irq_q     <= 1'b0;
        end else begin
            dir_q     <= dir_d;
            out_q     <= out_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            status_q  <= status_d;
            hist_q    <= sampled;
            if (!warm_done) begin
                warm_q <= warm_q - 1'b1;
            end
            data_o_q  <= rd_word;
            // irq follows the current STATUS, so it lags STATUS by a cycle.
            irq_q     <= |status_q;
        end
    end

    // Reset clears these registers asynchronously, so pads are released and
    // irq drops as soon as rst_n falls.
    assign pin_o  = out_q;
    assign pin_oe = dir_q;
    assign data_o = data_o_q;
    assign irq    = irq_q;

endmodule : gpio_irq

// File: tb/tb_gpio_irq.sv
// Directed testbench for gpio_irq (WIDTH=8, SYNC_STAGES=2).
// Inputs change on the falling clock edge; outputs are checked on the falling
// edge, half a cycle away from the rising edge that updates the design.
module tb_gpio_irq;
    import gpio_pkg::*;

    localparam int WIDTH = 8;

    // ---------------- clock / reset ----------------
    logic             clk;
    logic             rst_n;
    logic             valid;
    logic [2:0]       addr;
    logic [31:0]      data;
    logic [31:0]      data_o;
    logic [WIDTH-1:0] pin_i;
    logic [WIDTH-1:0] pin_o;
    logic [WIDTH-1:0] pin_oe;
    logic             irq;

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    gpio_irq #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (2)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .valid  (valid),
        .addr   (addr),
        .data   (data),
        .data_o (data_o),
        .pin_i  (pin_i),
        .pin_o  (pin_o),
        .pin_oe (pin_oe),
        .irq    (irq)
    );

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called at a falling edge; returns at the falling edge after the write.
    task automatic do_write(input logic [2:0] a, input logic [31:0] d);
        valid = 1'b1;
        addr  = a;
        data  = d;
        @(negedge clk);
        valid = 1'b0;
        data  = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Bounded wait for irq to rise; an expired bound is a failed check.
    task automatic wait_irq(input int max_cycles);
        int n;
        n = 0;
        while (irq !== 1'b1 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        check("irq_wait", {31'b0, irq}, 32'h1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_n = 1'b0;
        valid = 1'b0;
        addr  = '0;
        data  = '0;
        pin_i = '0;

        // Reset state
        idle(3);
        check("rst_pin_o",  {24'b0, pin_o},  32'h0);
        check("rst_pin_oe", {24'b0, pin_oe}, 32'h0);
        check("rst_irq",    {31'b0, irq},    32'h0);
        check("rst_data_o", data_o,          32'h0);
        rst_n = 1'b1;
        idle(5);
        check("warm_status", {24'b0, dut.status_q}, 32'h0);

        // Output register operations, one cycle write-to-pin latency
        do_write(ADDR_DIR, 32'h0000_00FF);
        check("dir_pin_oe", {24'b0, pin_oe}, 32'hFF);
        do_write(ADDR_OUT, 32'h0000_000F);
        check("out_wr", {24'b0, pin_o}, 32'h0F);
        do_write(ADDR_OUT_SET, 32'h0000_0030);
        check("out_set", {24'b0, pin_o}, 32'h3F);
        do_write(ADDR_OUT_CLR, 32'h0000_0001);
        check("out_clr", {24'b0, pin_o}, 32'h3E);
        do_write(ADDR_OUT_TGL, 32'h0000_0081);
        check("out_tgl", {24'b0, pin_o}, 32'hBF);
        check("pin_oe_hold", {24'b0, pin_oe}, 32'hFF);

        // Readback
        addr = ADDR_DIR;
        @(negedge clk);
        check("rd_dir", data_o, 32'h0000_00FF);
        addr = ADDR_OUT;
        @(negedge clk);
        check("rd_out", data_o, 32'h0000_00BF);
        addr = ADDR_OUT_TGL;
        @(negedge clk);
        check("rd_out_tgl", data_o, 32'h0000_00BF);

        // Upper write bits ignored
        do_write(ADDR_FALL_EN, 32'hFFFF_FF00);
        addr = ADDR_FALL_EN;
        @(negedge clk);
        check("rd_fall_upper", data_o, 32'h0);

        // Rising edge: STATUS 3 cycles after the pin change, irq one later
        do_write(ADDR_RISE_EN, 32'h0000_0001);
        addr = ADDR_STATUS;
        pin_i[0] = 1'b1;
        idle(2);
        check("rise_lat2", {24'b0, dut.status_q}, 32'h0);
        idle(1);
        check("rise_lat3", {24'b0, dut.status_q}, 32'h1);
        check("irq_lat3", {31'b0, irq}, 32'h0);
        idle(1);
        check("irq_lat4", {31'b0, irq}, 32'h1);
        check("rd_status", data_o, 32'h1);

        // W1C clears, irq falls one cycle later
        do_write(ADDR_STATUS, 32'h0000_0001);
        check("w1c_status", {24'b0, dut.status_q}, 32'h0);
        check("w1c_irq_lag", {31'b0, irq}, 32'h1);
        idle(1);
        check("w1c_irq", {31'b0, irq}, 32'h0);

        // Falling edge with FALL_EN=0: no status
        do_write(ADDR_FALL_EN, 32'h0);
        pin_i[0] = 1'b0;
        idle(6);
        check("fall_dis_status", {24'b0, dut.status_q}, 32'h0);
        check("fall_dis_irq", {31'b0, irq}, 32'h0);

        // Falling edge enabled on pin 1; its rising edge is not enabled
        do_write(ADDR_FALL_EN, 32'h0000_0002);
        pin_i[1] = 1'b1;
        idle(5);
        check("rise1_dis", {24'b0, dut.status_q}, 32'h0);
        pin_i[1] = 1'b0;
        idle(2);
        check("fall1_lat2", {24'b0, dut.status_q}, 32'h0);
        idle(1);
        check("fall1_lat3", {24'b0, dut.status_q}, 32'h2);

        // Sticky after enable cleared
        do_write(ADDR_FALL_EN, 32'h0);
        addr = ADDR_STATUS;
        idle(2);
        check("sticky_rd", data_o, 32'h2);
        check("sticky_irq", {31'b0, irq}, 32'h1);
        do_write(ADDR_STATUS, 32'h0000_0002);
        check("w1c_bit1", {24'b0, dut.status_q}, 32'h0);

        // W1C coinciding with a new qualifying rise: set wins
        pin_i[0] = 1'b1;
        idle(3);
        check("rise0_again", {24'b0, dut.status_q}, 32'h1);
        pin_i[0] = 1'b0;
        idle(3);
        pin_i[0] = 1'b1;
        idle(2);
        do_write(ADDR_STATUS, 32'h0000_0001);
        check("set_priority", {24'b0, dut.status_q}, 32'h1);
        do_write(ADDR_STATUS, 32'h0000_0001);
        check("w1c_after_prio", {24'b0, dut.status_q}, 32'h0);

        // Pins high through reset release: warm-up masks the false rise
        rst_n = 1'b0;
        pin_i = 8'hFF;
        idle(2);
        check("rst2_pin_oe", {24'b0, pin_oe}, 32'h0);
        check("rst2_status", {24'b0, dut.status_q}, 32'h0);
        rst_n = 1'b1;
        do_write(ADDR_RISE_EN, 32'h0000_00FF);
        addr = ADDR_STATUS;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("warm_mask", {23'b0, irq, dut.status_q}, 32'h0);
        end
        check("warm_rd", data_o, 32'h0);

        // Mid-operation reset with DIR=0xFF and irq=1
        do_write(ADDR_DIR, 32'h0000_00FF);
        pin_i[2] = 1'b0;
        idle(4);
        pin_i[2] = 1'b1;
        wait_irq(10);
        check("pre_rst_oe", {24'b0, pin_oe}, 32'hFF);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_oe", {24'b0, pin_oe}, 32'h0);
        check("async_rst_irq", {31'b0, irq}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // ---------------- report ----------------
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_gpio_irq
